msg_serializer: RTL and testbench



---
 rtl/msg_serializer_if.sv | 27 ++
 rtl/msg_serializer.sv | 133 +++++++++++++
 tb/tb_msg_serializer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msg_serializer_if.sv
// Handshake bundle between a parallel message source, the serializer and a byte sink.
// The slave modport is the serializer's view; master is the surrounding environment.
interface msg_serializer_if;
  logic        msg_valid;
  logic        msg_ready;
  logic [7:0]  msg_type;
  logic [7:0]  stock_id;
  logic [31:0] order_id;
  logic [31:0] price;
  logic [31:0] quantity;
  logic [15:0] padding;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_out;
  logic        busy;
  logic        done;

  modport slave (
    input  msg_valid, msg_type, stock_id, order_id, price, quantity, padding, byte_ready,
    output msg_ready, byte_valid, byte_out, busy, done
  );

  modport master (
    output msg_valid, msg_type, stock_id, order_id, price, quantity, padding, byte_ready,
    input  msg_ready, byte_valid, byte_out, busy, done
  );
endinterface

// File: rtl/msg_serializer.sv
// Serializes one parsed market-data message into 16 bytes, MSB first per field.
// Define MSG_CHECKSUM_EN to send a 16-bit sum of bytes 0-13 in place of the padding field.
module msg_serializer #(
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  msg_serializer_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP);
  localparam bit         HAS_GAP  = (IDLE_GAP != 0);

  state_e       state_q;
  logic [127:0] shreg_q;
  logic [127:0] shreg_d;
  logic [3:0]   byte_cnt_q;
  logic [3:0]   gap_cnt_q;
  logic         msg_ready_q;
  logic         byte_valid_q;
  logic         busy_q;
  logic         done_q;
  logic         accept;

  assign accept = (state_q == S_IDLE) && bus.msg_valid && msg_ready_q;

`ifdef MSG_CHECKSUM_EN
  logic        byte_hs;
  logic [15:0] csum_q;
  logic [15:0] csum_d;

  assign byte_hs = byte_valid_q && bus.byte_ready;
  assign csum_d  = csum_q + {8'd0, shreg_q[127:120]};

  // The sum is complete as byte 13 leaves, so it is spliced into the top of the
  // register on that same shift and goes out as bytes 14-15.
  always_comb begin
    shreg_d = {shreg_q[119:0], 8'h00};
    if (byte_cnt_q == 4'd13) begin
      shreg_d[127:112] = csum_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (accept) begin
      csum_q <= '0;
    end else if (byte_hs && (byte_cnt_q < 4'd14)) begin
      csum_q <= csum_d;
    end
  end
`else
  assign shreg_d = {shreg_q[119:0], 8'h00};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      msg_ready_q  <= 1'b1;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shreg_q      <= {bus.msg_type, bus.stock_id, bus.order_id,
                             bus.price, bus.quantity, bus.padding};
            byte_cnt_q   <= '0;
            state_q      <= S_SEND;
            msg_ready_q  <= 1'b0;
            byte_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end

        S_SEND: begin
          // Without byte_ready everything holds, so a stalled byte is neither lost nor repeated.
          if (bus.byte_ready) begin
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_q + 4'd1;
            if (byte_cnt_q == 4'd15) begin
              done_q       <= 1'b1;
              byte_valid_q <= 1'b0;
              if (HAS_GAP) begin
                gap_cnt_q <= GAP_LOAD;
                state_q   <= S_GAP;
              end else begin
                state_q     <= S_IDLE;
                msg_ready_q <= 1'b1;
                busy_q      <= 1'b0;
              end
            end
          end
        end

        S_GAP: begin
          gap_cnt_q <= gap_cnt_q - 4'd1;
          if (gap_cnt_q <= 4'd1) begin
            gap_cnt_q   <= '0;
            state_q     <= S_IDLE;
            msg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          msg_ready_q  <= 1'b1;
          byte_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.msg_ready  = msg_ready_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_out   = shreg_q[127:120];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_msg_serializer.sv
// Scoreboard bench for msg_serializer: stimulus pushes expected bytes, a negedge monitor pops them.
// A second instance with IDLE_GAP=3 is used for the inter-message gap timing.
`timescale 1ns/1ps
module tb_msg_serializer;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  msg_serializer_if if0 ();
  msg_serializer_if if3 ();

  msg_serializer #(.IDLE_GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  msg_serializer #(.IDLE_GAP(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries: {last_byte_of_message, byte}
  logic [8:0] exp_q[$];

  int   br_mode = 0;        // 0: always ready, 1: random, 2: manual
  logic br_auto = 1'b1;
  logic br_man  = 1'b1;
  assign if0.byte_ready = (br_mode == 2) ? br_man : br_auto;

  always @(posedge clk) begin
    #1;
    br_auto = (br_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  localparam logic [127:0] BASIC = {8'h41, 8'h07, 32'h11223344, 32'h000186A0,
                                    32'h00000064, 16'hBEEF};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: the byte stream is the field concatenation, bytes 14-15 optionally a byte sum.
  function automatic logic [127:0] model_stream(input logic [127:0] f);
    logic [127:0] v = f;
`ifdef MSG_CHECKSUM_EN
    int unsigned sum = 0;
    for (int i = 0; i < 14; i++) sum += int'(v[127-8*i -: 8]);
    v[15:0] = 16'(sum % 65536);
`endif
    return v;
  endfunction

  function automatic logic [127:0] rand_fields();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive_fields(input logic [127:0] f);
    if0.msg_type = f[127:120];
    if0.stock_id = f[119:112];
    if0.order_id = f[111:80];
    if0.price    = f[79:48];
    if0.quantity = f[47:16];
    if0.padding  = f[15:0];
  endtask

  task automatic push_expected(input logic [127:0] f);
    logic [127:0] v = model_stream(f);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'(i == 15), v[127-8*i -: 8]});
  endtask

  // Entered and left one time unit after a rising edge; holds msg_valid until accepted.
  task automatic send_msg(input logic [127:0] f);
    bit acc = 1'b0;
    int w   = 0;
    drive_fields(f);
    if0.msg_valid = 1'b1;
    while (!acc && w < 400) begin
      acc = if0.msg_ready;
      @(posedge clk); #1;
      w++;
    end
    if0.msg_valid = 1'b0;
    drive_fields(rand_fields());
    if (acc) begin
      push_expected(f);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: msg_ready never seen within %0d cycles", w);
    end
  endtask

  task automatic wait_done(input int exp_cycles, input string name);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = if0.done;
    end
    check(name, n, exp_cycles);
    @(posedge clk); #1;
  endtask

  // Monitor / scoreboard for the IDLE_GAP=0 instance
  bit         mon_en    = 1'b0;
  bit         done_pend = 1'b0;
  bit         stall_prev = 1'b0;
  bit         inflight;
  logic [7:0] out_prev  = 8'h00;
  logic [8:0] e;
  int         hs_total  = 0;
  int         msg_cnt   = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        check("rst_byte_valid", {31'd0, if0.byte_valid}, 32'd0);
        check("rst_done", {31'd0, if0.done}, 32'd0);
        exp_q.delete();
        done_pend  = 1'b0;
        stall_prev = 1'b0;
      end else begin
        inflight = (exp_q.size() != 0);
        check("byte_valid", {31'd0, if0.byte_valid}, {31'd0, inflight});
        check("busy", {31'd0, if0.busy}, {31'd0, inflight});
        check("msg_ready", {31'd0, if0.msg_ready}, {31'd0, !inflight});
        check("done", {31'd0, if0.done}, {31'd0, done_pend});
        if (stall_prev) check("hold_byte", {24'd0, if0.byte_out}, {24'd0, out_prev});
        done_pend  = 1'b0;
        stall_prev = if0.byte_valid && !if0.byte_ready;
        out_prev   = if0.byte_out;
        if (if0.byte_valid && if0.byte_ready && inflight) begin
          e = exp_q.pop_front();
          check("byte", {24'd0, if0.byte_out}, {24'd0, e[7:0]});
          hs_total++;
          if (e[8]) begin
            done_pend = 1'b1;
            msg_cnt++;
            $display("msg %0d: 16 bytes handshaken, last byte 0x%02h at %0t", msg_cnt, if0.byte_out, $time);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          w;
    int          acc_t[$];
    int          done_t[$];
    logic [7:0]  got[$];
    int          gapc;
    logic [127:0] fg;
    logic [127:0] vg;

    if0.msg_valid = 1'b0;
    drive_fields('0);
    if3.msg_valid  = 1'b0;
    if3.byte_ready = 1'b1;
    fg = rand_fields();
    if3.msg_type = fg[127:120];
    if3.stock_id = fg[119:112];
    if3.order_id = fg[111:80];
    if3.price    = fg[79:48];
    if3.quantity = fg[47:16];
    if3.padding  = fg[15:0];

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state of both instances
    @(negedge clk);
    check("reset_byte_valid0", {31'd0, if0.byte_valid}, 32'd0);
    check("reset_byte_out0", {24'd0, if0.byte_out}, 32'd0);
    check("reset_done0", {31'd0, if0.done}, 32'd0);
    check("reset_busy0", {31'd0, if0.busy}, 32'd0);
    check("reset_msg_ready0", {31'd0, if0.msg_ready}, 32'd1);
    check("reset_byte_valid3", {31'd0, if3.byte_valid}, 32'd0);
    check("reset_busy3", {31'd0, if3.busy}, 32'd0);
    check("reset_msg_ready3", {31'd0, if3.msg_ready}, 32'd1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic serialization with the sink always ready
    br_mode = 0;
    send_msg(BASIC);
    wait_done(17, "basic_done_latency");

    // Backpressure: three stalled cycles while byte 5 (0x44) is presented
    br_mode = 2;
    br_man  = 1'b1;
    send_msg(BASIC);
    repeat (5) @(posedge clk);
    #1 br_man = 1'b0;
    @(negedge clk);
    check("stall_byte_out", {24'd0, if0.byte_out}, 32'h44);
    check("stall_byte_valid", {31'd0, if0.byte_valid}, 32'd1);
    repeat (3) @(posedge clk);
    #1 br_man = 1'b1;
    // Counted from the restart point: unstalled 17, plus 3 stalls, minus 8 cycles already spent
    wait_done(17 + 3 - 8, "backpressure_done_latency");
    br_mode = 0;

    // Requests during a message are ignored; the held request goes in once ready
    send_msg(rand_fields());
    repeat (4) @(posedge clk);
    #1;
    drive_fields(rand_fields());
    if0.msg_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 if0.msg_valid = 1'b0;
    send_msg(rand_fields());
    wait_done(17, "queued_msg_done_latency");

    // Reset after byte 8 of a message aborts it
    send_msg(rand_fields());
    base = hs_total;
    w = 0;
    while ((hs_total - base) < 9 && w < 100) begin
      @(posedge clk);
      w++;
    end
    check("reset_point_reached", {31'd0, 1'((hs_total - base) >= 9)}, 32'd1);
    #1 reset = 1'b1;
    #1 check("async_reset_byte_valid", {31'd0, if0.byte_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    send_msg(BASIC);
    wait_done(17, "post_reset_done_latency");

    // Randomized traffic with random sink stalls
    br_mode = 1;
    for (int m = 0; m < 30; m++) begin
      send_msg(rand_fields());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    w = 0;
    while (exp_q.size() != 0 && w < 4000) begin
      @(posedge clk);
      w++;
    end
    check("random_drain", exp_q.size(), 32'd0);
    br_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Gap timing on the IDLE_GAP=3 instance with msg_valid held high
    vg = model_stream(fg);
    gapc = 0;
    if3.msg_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (if3.msg_ready) acc_t.push_back(c);
      if (!if3.byte_valid && !if3.msg_ready) gapc++;
      if (if3.done) done_t.push_back(c);
      if (if3.byte_valid && got.size() < 16) got.push_back(if3.byte_out);
    end
    @(posedge clk);
    #1 if3.msg_valid = 1'b0;
    check("gap_accept_count", acc_t.size(), 32'd4);
    check("gap_cycles", gapc, 32'd9);
    check("gap_done_count", done_t.size(), 32'd3);
    if (acc_t.size() >= 3) begin
      check("gap_period_1", acc_t[1] - acc_t[0], 32'd20);
      check("gap_period_2", acc_t[2] - acc_t[1], 32'd20);
    end
    if (acc_t.size() >= 1 && done_t.size() >= 1)
      check("gap_done_latency", done_t[0] - acc_t[0], 32'd17);
    check("gap_byte_count", got.size(), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check($sformatf("gap_byte_%0d", i), {24'd0, got[i]}, {24'd0, vg[127-8*i -: 8]});
    $display("gap instance: %0d accepts, %0d gap cycles, %0d done pulses", acc_t.size(), gapc, done_t.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
